// File: rtl/control_multi_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, state
// encodings, datapath select codes, error codes and the control bundle.
package control_multi_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   // FSM states, 4-bit encoding
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_HALT   = 4'd10
   } state_t;

   // ALUOp codes
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUSrcB codes
   localparam logic [1:0] SRCB_B        = 2'b00;
   localparam logic [1:0] SRCB_FOUR     = 2'b01;
   localparam logic [1:0] SRCB_SEXT     = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

   // PCSource codes
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // err_code values
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // Full set of control strobes produced for one state
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       halted;
   } ctrl_t;

   // States that talk to memory and therefore wait on mem_ready
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/control_multi_out_decode.sv
// Combinational state-to-control decode for the multi-cycle control unit.
// Moore outputs except the FETCH IR/PC load and the store completion pulse,
// which are qualified by mem_ready.
module mc_out_decode
   import control_multi_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   // Decode the current state into datapath strobes and selects
   always_comb begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.iord          = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.mem_to_reg    = 1'b0;
      ctrl.reg_dst       = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.alu_src_a     = 1'b0;
      ctrl.alu_src_b     = SRCB_B;
      ctrl.alu_op        = ALUOP_ADD;
      ctrl.pc_source     = PCSRC_ALU;
      ctrl.instr_done    = 1'b0;
      ctrl.halted        = 1'b0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
            end else begin
               ctrl.ir_write = 1'b0;
               ctrl.pc_write = 1'b0;
            end
         end
         S_DECODE: begin
            // branch target PC + (sext << 2) lands in ALUOut
            ctrl.alu_src_b = SRCB_SEXT_SH2;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            if (mem_ready) begin
               ctrl.instr_done = 1'b1;
            end else begin
               ctrl.instr_done = 1'b0;
            end
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         S_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: begin
            // unused encodings: keep every strobe quiet
            ctrl.halted = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/control_multi.sv
// Multi-cycle control FSM for the shared-memory MIPS datapath.
// Holds the state register, the memory-wait watchdog and the sticky error
// code; output decode lives in mc_out_decode.
module control_multi
   import control_multi_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       halted,
   output logic [1:0] err_code
);

   // The limit cycle is the WAIT_LIMIT-th consecutive wait cycle
   localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(WAIT_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam bit               WD_ON      = (WAIT_LIMIT != 0);

   state_t           state_r;
   state_t           next_state_s;
   logic [1:0]       err_code_r;
   logic [1:0]       next_err_s;
   logic [CNT_W-1:0] wait_cnt_r;
   logic [5:0]       opcode_r;
   logic             mem_wait_s;
   logic             timeout_s;
   ctrl_t            ctrl_s;

   assign mem_wait_s = is_mem_state(state_r) && !mem_ready;
   assign timeout_s  = WD_ON && mem_wait_s && (wait_cnt_r == LIMIT_LAST);

   // Next-state and error-code selection
   always_comb begin
      next_state_s = state_r;
      next_err_s   = err_code_r;
      case (state_r)
         S_FETCH: begin
            if (mem_ready) begin
               next_state_s = S_DECODE;
            end else if (timeout_s) begin
               next_state_s = S_HALT;
               next_err_s   = ERR_TIMEOUT;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_R:         next_state_s = S_EXEC;
               OP_LW, OP_SW: next_state_s = S_MEMADR;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_J:         next_state_s = S_JUMP;
               default: begin
                  next_state_s = S_HALT;
                  next_err_s   = ERR_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: begin
            // lw/sw choice comes from the opcode captured in DECODE
            if (opcode_r == OP_SW) begin
               next_state_s = S_MEMWR;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMRD: begin
            if (mem_ready) begin
               next_state_s = S_MEMWB;
            end else if (timeout_s) begin
               next_state_s = S_HALT;
               next_err_s   = ERR_TIMEOUT;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMWB:  next_state_s = S_FETCH;
         S_MEMWR: begin
            if (mem_ready) begin
               next_state_s = S_FETCH;
            end else if (timeout_s) begin
               next_state_s = S_HALT;
               next_err_s   = ERR_TIMEOUT;
            end else begin
               next_state_s = S_MEMWR;
            end
         end
         S_EXEC:   next_state_s = S_RWB;
         S_RWB:    next_state_s = S_FETCH;
         S_BRANCH: next_state_s = S_FETCH;
         S_JUMP:   next_state_s = S_FETCH;
         S_HALT:   next_state_s = S_HALT;
         default:  next_state_s = S_HALT;
      endcase
   end

   // State and sticky error register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_FETCH;
         err_code_r <= ERR_NONE;
      end else begin
         state_r    <= next_state_s;
         err_code_r <= next_err_s;
      end
   end

   // Memory wait counter: restarts on every state change, counts idle memory cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (next_state_s != state_r) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (mem_wait_s && (wait_cnt_r != CNT_MAX)) begin
         wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Opcode capture in DECODE for the later lw/sw split
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opcode_r <= 6'd0;
      end else if (state_r == S_DECODE) begin
         opcode_r <= opcode;
      end else begin
         opcode_r <= opcode_r;
      end
   end

   mc_out_decode u_out_decode (
      .state     (state_r),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_s)
   );

   assign PCWrite     = ctrl_s.pc_write;
   assign PCWriteCond = ctrl_s.pc_write_cond;
   assign IorD        = ctrl_s.iord;
   assign MemRead     = ctrl_s.mem_read;
   assign MemWrite    = ctrl_s.mem_write;
   assign IRWrite     = ctrl_s.ir_write;
   assign MemtoReg    = ctrl_s.mem_to_reg;
   assign RegDst      = ctrl_s.reg_dst;
   assign RegWrite    = ctrl_s.reg_write;
   assign ALUSrcA     = ctrl_s.alu_src_a;
   assign ALUSrcB     = ctrl_s.alu_src_b;
   assign ALUOp       = ctrl_s.alu_op;
   assign PCSource    = ctrl_s.pc_source;
   assign instr_done  = ctrl_s.instr_done;
   assign halted      = ctrl_s.halted;
   assign err_code    = err_code_r;

endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench for control_multi: each issued instruction pushes a
// per-instruction summary (cycle count, strobe counts, final selects) derived
// from the instruction-level timing rules; a monitor accumulates the DUT
// strobes and compares when instr_done pulses or halted rises.
module tb_control_multi;
   import control_multi_pkg::*;

   localparam int LIMIT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, halted;
   logic [1:0] ALUSrcB, ALUOp, PCSource, err_code;

   control_multi #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .halted(halted),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef enum int {K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ILL = 5} kind_e;

   typedef struct {
      int cycles, mem_rd, mem_wr, iord, irw, pcw, pcwc, regw;
      int regdst, mtor, pcsrc, aluop, srca, err, halt;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass   = 0;
   int   n_checks = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
   endtask

   // Instruction-level reference: what one instruction should look like in total
   function automatic exp_t model(input kind_e k, input int wf, input int wm);
      exp_t e;
      e = '{default: 0};
      e.pcsrc = -1;
      if (wf >= LIMIT) begin
         e.cycles = LIMIT; e.mem_rd = LIMIT; e.err = 2; e.halt = 1;
         return e;
      end
      e.cycles = wf + 2; e.mem_rd = wf + 1; e.irw = 1; e.pcw = 1; e.pcsrc = 0;
      case (k)
         K_ILL: begin e.err = 1; e.halt = 1; end
         K_R:   begin e.cycles += 2; e.regw = 1; e.regdst = 1; e.aluop = 2; e.srca = 1; end
         K_BEQ: begin e.cycles += 1; e.pcwc = 1; e.pcsrc = 1; e.aluop = 1; e.srca = 1; end
         K_J:   begin e.cycles += 1; e.pcw = 2; e.pcsrc = 2; end
         K_LW: begin
            e.cycles += 1; e.srca = 1;
            if (wm >= LIMIT) begin
               e.cycles += LIMIT; e.mem_rd += LIMIT; e.iord = LIMIT; e.err = 2; e.halt = 1;
            end else begin
               e.cycles += wm + 2; e.mem_rd += wm + 1; e.iord = wm + 1;
               e.regw = 1; e.mtor = 1;
            end
         end
         default: begin // K_SW
            e.cycles += 1; e.srca = 1;
            if (wm >= LIMIT) begin
               e.cycles += LIMIT; e.mem_wr = LIMIT; e.iord = LIMIT; e.err = 2; e.halt = 1;
            end else begin
               e.cycles += wm + 1; e.mem_wr = wm + 1; e.iord = wm + 1;
            end
         end
      endcase
      return e;
   endfunction

   // Monitor accumulators
   int a_cyc, a_rd, a_wr, a_iord, a_irw, a_pcw, a_pcwc, a_regw;
   int a_regdst, a_mtor, a_pcsrc, a_aluop, a_srca;
   int halt_err;

   task automatic clr_acc();
      a_cyc = 0; a_rd = 0; a_wr = 0; a_iord = 0; a_irw = 0; a_pcw = 0; a_pcwc = 0;
      a_regw = 0; a_regdst = 0; a_mtor = 0; a_pcsrc = -1; a_aluop = 0; a_srca = 0;
   endtask

   task automatic compare_rec(input exp_t e, input int got_halt);
      chk("is_halt", got_halt, e.halt);
      chk("cycles", a_cyc, e.cycles);
      chk("memread_cycles", a_rd, e.mem_rd);
      chk("memwrite_cycles", a_wr, e.mem_wr);
      chk("iord_cycles", a_iord, e.iord);
      chk("irwrite_count", a_irw, e.irw);
      chk("pcwrite_count", a_pcw, e.pcw);
      chk("pcwritecond_count", a_pcwc, e.pcwc);
      chk("regwrite_count", a_regw, e.regw);
      chk("regdst", a_regdst, e.regdst);
      chk("memtoreg", a_mtor, e.mtor);
      chk("pcsource_last", a_pcsrc, e.pcsrc);
      chk("aluop_or", a_aluop, e.aluop);
      chk("alusrca_cycles", a_srca, e.srca);
      chk("err_code", int'(err_code), e.err);
   endtask

   // Monitor: sample on the falling edge, compare on retire or halt entry
   initial begin : monitor
      exp_t e;
      bit   prev_halted;
      prev_halted = 1'b0;
      halt_err = 0;
      clr_acc();
      forever begin
         @(negedge clk);
         if (!rst) begin
            clr_acc();
            prev_halted = 1'b0;
         end else if (halted) begin
            if (!prev_halted) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_halt", 1, 0);
                  halt_err = int'(err_code);
               end else begin
                  e = exp_q.pop_front();
                  compare_rec(e, 1);
                  halt_err = e.err;
               end
               prev_halted = 1'b1;
               clr_acc();
            end else begin
               chk("halt_strobes", int'({PCWrite, PCWriteCond, MemRead, MemWrite,
                                         IRWrite, RegWrite, instr_done}), 0);
               chk("halt_err_stable", int'(err_code), halt_err);
            end
         end else begin
            a_cyc++;
            a_rd   += int'(MemRead);
            a_wr   += int'(MemWrite);
            a_iord += int'(IorD);
            a_irw  += int'(IRWrite);
            a_pcw  += int'(PCWrite);
            a_pcwc += int'(PCWriteCond);
            a_srca += int'(ALUSrcA);
            a_aluop = a_aluop | int'(ALUOp);
            if (PCWrite || PCWriteCond) a_pcsrc = int'(PCSource);
            if (RegWrite) begin
               a_regw++;
               a_regdst = int'(RegDst);
               a_mtor   = int'(MemtoReg);
            end
            if (instr_done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_instr_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  compare_rec(e, 0);
               end
               clr_acc();
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [5:0] rnd6();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
   endfunction

   // One clock cycle of inputs, applied just after the rising edge
   task automatic cyc(input logic mr, input logic [5:0] op);
      mem_ready = mr;
      opcode    = op;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_memread", int'(MemRead), 1);
      chk("rst_alusrcb", int'(ALUSrcB), 1);
      chk("rst_write_strobes", int'({PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite}), 0);
      chk("rst_instr_done", int'(instr_done), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_err_code", int'(err_code), 0);
   endtask

   task automatic do_reset();
      mem_ready = 1'b0;
      rst = 1'b0;
      if (exp_q.size() != 0) chk("pending_at_reset", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic halt_idle();
      repeat (20) cyc(rbit(), rnd6());
      chk("halt_sticky", int'(halted), 1);
      do_reset();
   endtask

   // Memory phase: w idle cycles then ready, or a watchdog expiry if w >= LIMIT
   task automatic mem_phase(input int w, output bit to);
      to = (w >= LIMIT);
      if (to) begin
         repeat (LIMIT) cyc(1'b0, rnd6());
      end else begin
         repeat (w) cyc(1'b0, rnd6());
         cyc(1'b1, rnd6());
      end
   endtask

   task automatic run_instr(input kind_e k, input logic [5:0] op, input int wf, input int wm);
      bit to;
      exp_q.push_back(model(k, wf, wm));
      mem_phase(wf, to);
      if (to) begin
         halt_idle();
         return;
      end
      cyc(rbit(), op); // DECODE: mem_ready is don't-care here
      case (k)
         K_ILL: halt_idle();
         K_R:   repeat (2) cyc(rbit(), rnd6());
         K_LW, K_SW: begin
            cyc(rbit(), rnd6()); // MEMADR with a scrambled opcode input
            mem_phase(wm, to);
            if (to) halt_idle();
            else if (k == K_LW) cyc(rbit(), rnd6());
         end
         default: cyc(rbit(), rnd6());
      endcase
   endtask

   function automatic int rnd_wait();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 5));
      return int'($urandom_range(0, 1));
   endfunction

   initial begin : stim
      kind_e      k;
      logic [5:0] op;
      int         r;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b1;

      // directed sequences
      run_instr(K_R,   6'h00, 0, 0);
      run_instr(K_LW,  6'h23, 0, 3);
      run_instr(K_SW,  6'h2B, 0, 0);
      run_instr(K_BEQ, 6'h04, 0, 0);
      run_instr(K_J,   6'h02, 0, 0);
      run_instr(K_ILL, 6'h3F, 0, 0);
      run_instr(K_R,   6'h00, 4, 0);  // fetch watchdog expiry
      run_instr(K_R,   6'h00, 3, 0);  // ready in the limit cycle wins
      run_instr(K_SW,  6'h2B, 1, 4);  // store watchdog expiry
      run_instr(K_LW,  6'h23, 2, 3);  // read ready in the limit cycle

      // reset while a store is waiting with MemWrite high
      cyc(1'b1, rnd6());
      cyc(rbit(), 6'h2B);
      cyc(rbit(), rnd6());
      cyc(1'b0, rnd6());
      mem_ready = 1'b0;
      #2;
      chk("memwrite_before_abort", int'(MemWrite), 1);
      rst = 1'b0;
      #1;
      chk("memwrite_async_drop", int'(MemWrite), 0);
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("fetch_after_abort_memread", int'(MemRead), 1);
      chk("fetch_after_abort_memwrite", int'(MemWrite), 0);

      // randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 11));
         if (r == 11) begin
            k = K_ILL;
            op = rnd6();
            while (is_legal(op)) op = rnd6();
         end else begin
            k = kind_e'(r % 5);
            case (k)
               K_R:     op = 6'h00;
               K_LW:    op = 6'h23;
               K_SW:    op = 6'h2B;
               K_BEQ:   op = 6'h04;
               default: op = 6'h02;
            endcase
         end
         run_instr(k, op, rnd_wait(), rnd_wait());
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
